// File: rtl/ball_collision_scheduler.sv
// Per-frame ball scheduler: moves the ball, scans players round-robin for a hit,
// drives a shared multi-cycle collider and commits at most one collision per frame.
module ball_collision_scheduler #(
    parameter int unsigned NUM_PLAYERS  = 4,
    parameter int unsigned HIT_RADIUS   = 16,
    parameter int unsigned COLLIDER_LAT = 2,
    parameter int          BALL_X0      = 320,
    parameter int          BALL_Y0      = 240,
    parameter int          DIR_X0       = 1,
    parameter int          DIR_Y0       = 1,
    localparam int unsigned IDXW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       frame_tick,
    input  logic [10*NUM_PLAYERS-1:0]  player_x,
    input  logic [10*NUM_PLAYERS-1:0]  player_y,
    output logic [18:0]                col_ball_x,
    output logic [18:0]                col_ball_y,
    output logic [18:0]                col_dir_x,
    output logic [18:0]                col_dir_y,
    output logic [9:0]                 col_player_x,
    output logic [9:0]                 col_player_y,
    input  logic signed [18:0]         col_new_x,
    input  logic signed [18:0]         col_new_y,
    input  logic signed [18:0]         col_new_dir_x,
    input  logic signed [18:0]         col_new_dir_y,
    output logic signed [18:0]         ball_x,
    output logic signed [18:0]         ball_y,
    output logic signed [18:0]         ball_dir_x,
    output logic signed [18:0]         ball_dir_y,
    output logic                       hit_valid,
    output logic [IDXW-1:0]            hit_player,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       overrun
);

    localparam int unsigned PW    = 10;
    localparam int unsigned CNTW  = $clog2(NUM_PLAYERS + 1);
    localparam int unsigned WAITW = (COLLIDER_LAT > 1) ? $clog2(COLLIDER_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_MOVE, S_SCAN, S_WAIT, S_COMMIT, S_DONE
    } state_t;

    state_t            state, next_state;
    logic [IDXW-1:0]   scan_idx;
    logic [IDXW-1:0]   start_ptr;
    logic [CNTW-1:0]   miss_cnt;
    logic [WAITW-1:0]  wait_cnt;
    logic              hit_seen;
    logic              degen_r;

    logic [PW-1:0]     cur_px, cur_py;
    logic signed [19:0] dx, dy, adx, ady;
    logic              hit_now, degen_now;
    logic              hit_valid_d, frame_done_d, busy_d;

    // Round-robin increment of a player index
    function automatic logic [IDXW-1:0] wrap_inc(input logic [IDXW-1:0] i);
        return (32'(i) == NUM_PLAYERS - 1) ? '0 : i + 1'b1;
    endfunction

    // Per-axis window test against the player currently under the scan index
    always_comb begin
        cur_px    = player_x[32'(scan_idx)*PW +: PW];
        cur_py    = player_y[32'(scan_idx)*PW +: PW];
        dx        = {ball_x[18], ball_x} - {10'd0, cur_px};
        dy        = {ball_y[18], ball_y} - {10'd0, cur_py};
        adx       = dx[19] ? -dx : dx;
        ady       = dy[19] ? -dy : dy;
        hit_now   = ($unsigned(adx) < 20'(HIT_RADIUS)) && ($unsigned(ady) < 20'(HIT_RADIUS));
        degen_now = (ball_x == {9'd0, cur_px});
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (frame_tick) next_state = S_MOVE;
            S_MOVE:   next_state = S_SCAN;
            S_SCAN: begin
                if (hit_now)
                    next_state = (degen_now || COLLIDER_LAT == 0) ? S_COMMIT : S_WAIT;
                else if (miss_cnt == CNTW'(NUM_PLAYERS - 1))
                    next_state = S_DONE;
            end
            S_WAIT:   if (wait_cnt == WAITW'(COLLIDER_LAT - 1)) next_state = S_COMMIT;
            S_COMMIT: next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Output decode, registered below so pulses align with the state they mark
    always_comb begin
        hit_valid_d  = (next_state == S_COMMIT);
        frame_done_d = (next_state == S_DONE);
        busy_d       = (next_state != S_IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ball_x       <= 19'(BALL_X0);
            ball_y       <= 19'(BALL_Y0);
            ball_dir_x   <= 19'(DIR_X0);
            ball_dir_y   <= 19'(DIR_Y0);
            col_ball_x   <= '0;
            col_ball_y   <= '0;
            col_dir_x    <= '0;
            col_dir_y    <= '0;
            col_player_x <= '0;
            col_player_y <= '0;
            hit_valid    <= 1'b0;
            hit_player   <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            overrun      <= 1'b0;
            scan_idx     <= '0;
            start_ptr    <= '0;
            miss_cnt     <= '0;
            wait_cnt     <= '0;
            hit_seen     <= 1'b0;
            degen_r      <= 1'b0;
        end else begin
            hit_valid  <= hit_valid_d;
            frame_done <= frame_done_d;
            busy       <= busy_d;
            if (frame_tick && busy) overrun <= 1'b1;
            case (state)
                S_MOVE: begin
                    ball_x   <= ball_x + ball_dir_x;
                    ball_y   <= ball_y + ball_dir_y;
                    scan_idx <= start_ptr;
                    miss_cnt <= '0;
                    hit_seen <= 1'b0;
                end
                S_SCAN: begin
                    if (hit_now) begin
                        hit_player <= scan_idx;
                        hit_seen   <= 1'b1;
                        degen_r    <= degen_now;
                        wait_cnt   <= '0;
                        if (!degen_now) begin
                            col_ball_x   <= ball_x;
                            col_ball_y   <= ball_y;
                            col_dir_x    <= ball_dir_x;
                            col_dir_y    <= ball_dir_y;
                            col_player_x <= cur_px;
                            col_player_y <= cur_py;
                        end
                    end else begin
                        scan_idx <= wrap_inc(scan_idx);
                        miss_cnt <= miss_cnt + 1'b1;
                    end
                end
                S_WAIT: wait_cnt <= wait_cnt + 1'b1;
                S_COMMIT: begin
                    if (degen_r) begin
                        ball_dir_y <= -ball_dir_y;
                    end else begin
                        ball_x     <= col_new_x;
                        ball_y     <= col_new_y;
                        ball_dir_x <= col_new_dir_x;
                        ball_dir_y <= col_new_dir_y;
                    end
                end
                S_DONE: start_ptr <= hit_seen ? wrap_inc(hit_player) : wrap_inc(start_ptr);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_collision_scheduler.sv
// Bench for ball_collision_scheduler: directed scenarios plus randomized frames
// checked against a frame-level reference model.
module tb_ball_collision_scheduler;

    localparam int N   = 4;
    localparam int R   = 16;
    localparam int LAT = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               frame_tick;
    logic [10*N-1:0]    player_x, player_y;
    logic [18:0]        col_ball_x, col_ball_y, col_dir_x, col_dir_y;
    logic [9:0]         col_player_x, col_player_y;
    logic signed [18:0] col_new_x, col_new_y, col_new_dir_x, col_new_dir_y;
    logic signed [18:0] ball_x, ball_y, ball_dir_x, ball_dir_y;
    logic               hit_valid;
    logic [1:0]         hit_player;
    logic               busy, frame_done, overrun;

    ball_collision_scheduler #(
        .NUM_PLAYERS(N), .HIT_RADIUS(R), .COLLIDER_LAT(LAT),
        .BALL_X0(320), .BALL_Y0(240), .DIR_X0(1), .DIR_Y0(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .player_x(player_x), .player_y(player_y),
        .col_ball_x(col_ball_x), .col_ball_y(col_ball_y),
        .col_dir_x(col_dir_x), .col_dir_y(col_dir_y),
        .col_player_x(col_player_x), .col_player_y(col_player_y),
        .col_new_x(col_new_x), .col_new_y(col_new_y),
        .col_new_dir_x(col_new_dir_x), .col_new_dir_y(col_new_dir_y),
        .ball_x(ball_x), .ball_y(ball_y), .ball_dir_x(ball_dir_x), .ball_dir_y(ball_dir_y),
        .hit_valid(hit_valid), .hit_player(hit_player),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state
    logic signed [18:0] m_bx, m_by, m_dx, m_dy;
    logic signed [18:0] cn_x, cn_y, cn_dx, cn_dy;
    int                 m_start;
    bit                 m_over;
    int                 px[N];
    int                 py[N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic model_reset();
        m_bx = 19'(320); m_by = 19'(240); m_dx = 19'(1); m_dy = 19'(1);
        m_start = 0; m_over = 1'b0;
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < N; k++) begin
            player_x[k*10 +: 10] = 10'(px[k]);
            player_y[k*10 +: 10] = 10'(py[k]);
        end
        col_new_x = cn_x; col_new_y = cn_y; col_new_dir_x = cn_dx; col_new_dir_y = cn_dy;
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        model_reset();
    endtask

    task automatic set_far();
        for (int k = 0; k < N; k++) begin px[k] = 0; py[k] = 0; end
    endtask

    // One frame: predict from the rules, run the DUT, compare.
    // extra: cycle index (1-based after the tick) at which a second tick is driven; 0 = none.
    task automatic run_frame(input string tag, input int extra);
        logic signed [18:0] nbx, nby, ex, ey, edx, edy;
        logic [18:0] e_cbx, e_cby;
        int  e_hit, e_p, e_k, e_hcyc, e_dcyc, ddx, ddy, k;
        bit  e_degen;
        int  got_h, got_d, hv_n, hp_seen;

        nbx = m_bx + m_dx; nby = m_by + m_dy;
        e_hit = 0; e_p = -1; e_k = 0; e_degen = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = (m_start + i) % N;
            ddx = int'(nbx) - px[k]; if (ddx < 0) ddx = -ddx;
            ddy = int'(nby) - py[k]; if (ddy < 0) ddy = -ddy;
            if (e_hit == 0 && ddx < R && ddy < R) begin
                e_hit = 1; e_p = i; e_k = k; e_degen = (int'(nbx) == px[k]);
            end
        end
        if (e_hit != 0) begin
            e_hcyc = e_degen ? e_p + 3 : e_p + 3 + LAT;
            e_dcyc = e_hcyc + 1;
            if (e_degen) begin ex = nbx; ey = nby; edx = m_dx; edy = -m_dy; end
            else begin ex = cn_x; ey = cn_y; edx = cn_dx; edy = cn_dy; end
        end else begin
            e_hcyc = -1; e_dcyc = N + 2;
            ex = nbx; ey = nby; edx = m_dx; edy = m_dy;
        end
        e_cbx = nbx; e_cby = nby;

        drive_inputs();
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk);
        got_h = -1; got_d = -1; hv_n = 0; hp_seen = 0;
        for (int c = 1; c <= 40; c++) begin
            frame_tick = (c == extra);
            if (hit_valid === 1'b1) begin
                hv_n++;
                if (got_h < 0) begin got_h = c; hp_seen = int'(hit_player); end
            end
            if (frame_done === 1'b1 && got_d < 0) got_d = c;
            if (got_d >= 0) break;
            @(negedge clk);
        end
        if (extra >= 1 && extra <= e_dcyc) m_over = 1'b1;

        check({tag, ".done_cycle"}, got_d, e_dcyc);
        check({tag, ".hit_cycle"}, got_h, e_hcyc);
        check({tag, ".hit_count"}, hv_n, e_hit);
        if (e_hit != 0) begin
            check({tag, ".hit_player"}, hp_seen, e_k);
            if (!e_degen) begin
                check({tag, ".col_player_x"}, col_player_x, px[e_k]);
                check({tag, ".col_player_y"}, col_player_y, py[e_k]);
                check({tag, ".col_ball_x"}, col_ball_x, e_cbx);
                check({tag, ".col_ball_y"}, col_ball_y, e_cby);
            end
        end
        check({tag, ".ball_x"}, ball_x, ex);
        check({tag, ".ball_y"}, ball_y, ey);
        check({tag, ".dir_x"}, ball_dir_x, edx);
        check({tag, ".dir_y"}, ball_dir_y, edy);
        @(negedge clk); frame_tick = 1'b0;
        check({tag, ".idle_busy"}, busy, 0);
        check({tag, ".overrun"}, overrun, m_over);

        m_bx = ex; m_by = ey; m_dx = edx; m_dy = edy;
        m_start = (e_hit != 0) ? (e_k + 1) % N : (m_start + 1) % N;
    endtask

    int rst_hv;
    int bound;
    logic signed [18:0] pbx, pby;

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0;
        set_far(); cn_x = '0; cn_y = '0; cn_dx = '0; cn_dy = '0;
        drive_inputs();
        model_reset();
        #12;
        check("reset.ball_x", ball_x, 320);
        check("reset.ball_y", ball_y, 240);
        check("reset.dir_x", ball_dir_x, 1);
        check("reset.dir_y", ball_dir_y, 1);
        check("reset.busy", busy, 0);
        check("reset.hit_valid", hit_valid, 0);
        check("reset.hit_player", hit_player, 0);
        check("reset.frame_done", frame_done, 0);
        check("reset.overrun", overrun, 0);
        check("reset.col_ball_x", col_ball_x, 0);
        check("reset.col_player_x", col_player_x, 0);
        @(negedge clk); rst_n = 1'b1;

        // No players near
        run_frame("nohit", 0);
        check("nohit.ball_x_abs", ball_x, 321);

        // Player 2 hit, collider returns (300,230,-2,-1)
        px[2] = 330; py[2] = 250;
        cn_x = 19'(300); cn_y = 19'(230); cn_dx = -19'(2); cn_dy = -19'(1);
        run_frame("hit_p2", 0);
        check("hit_p2.col_player_x_abs", col_player_x, 330);
        check("hit_p2.hit_player_abs", hit_player, 2);

        // Two players in window: arbitration rotates
        do_reset();
        set_far(); px[0] = 325; py[0] = 245; px[1] = 325; py[1] = 245;
        cn_x = 19'(320); cn_y = 19'(240); cn_dx = 19'(1); cn_dy = 19'(1);
        run_frame("arb1", 0);
        check("arb1.hit_player_abs", hit_player, 0);
        run_frame("arb2", 0);
        check("arb2.hit_player_abs", hit_player, 1);

        // Degenerate hit at scan position 0
        do_reset();
        set_far(); px[3] = 330; py[3] = 250;
        cn_x = 19'(321); cn_y = 19'(241); cn_dx = 19'(1); cn_dy = 19'(1);
        run_frame("pre_degen", 0);
        set_far(); px[0] = 322; py[0] = 242;
        run_frame("degen", 0);
        check("degen.dir_y_abs", ball_dir_y, -1);

        // Overrun: tick while busy, and tick coincident with frame_done
        do_reset();
        set_far();
        run_frame("ovr_mid", 2);
        check("ovr_mid.overrun_abs", overrun, 1);
        run_frame("ovr_sticky", 0);
        do_reset();
        check("ovr.cleared_by_reset", overrun, 0);
        run_frame("ovr_done", N + 2);

        // Reset during WAIT abandons the frame
        do_reset();
        set_far(); px[0] = 330; py[0] = 250;
        cn_x = 19'(10); cn_y = 19'(10); cn_dx = 19'(1); cn_dy = 19'(1);
        drive_inputs();
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rstwait.busy_before", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rstwait.busy", busy, 0);
        check("rstwait.ball_x", ball_x, 320);
        check("rstwait.ball_y", ball_y, 240);
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        rst_hv = 0;
        bound = 0;
        while (bound < 8) begin
            if (hit_valid === 1'b1) rst_hv++;
            @(negedge clk);
            bound++;
        end
        check("rstwait.no_hit", rst_hv, 0);
        check("rstwait.busy_after", busy, 0);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            pbx = m_bx + m_dx; pby = m_by + m_dy;
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    px[k] = int'(pbx) + int'($urandom_range(0, 40)) - 20;
                    py[k] = int'(pby) + int'($urandom_range(0, 40)) - 20;
                    if ($urandom_range(0, 7) == 0) px[k] = int'(pbx);
                end else begin
                    px[k] = int'($urandom_range(0, 1023));
                    py[k] = int'($urandom_range(0, 1023));
                end
                if (px[k] < 0) px[k] = 0;
                if (px[k] > 1023) px[k] = 1023;
                if (py[k] < 0) py[k] = 0;
                if (py[k] > 1023) py[k] = 1023;
            end
            cn_x  = 19'($urandom_range(20, 1000));
            cn_y  = 19'($urandom_range(20, 700));
            cn_dx = 19'(int'($urandom_range(0, 6)) - 3);
            cn_dy = 19'(int'($urandom_range(0, 6)) - 3);
            run_frame($sformatf("rnd%0d", f),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
